// File: rtl/psram_arbiter_if.sv
// rtl/psram_arbiter_if.sv - requester and psram controller signals shared by the arbiter
interface psram_arbiter_if;
  logic        i_a_req;
  logic        i_a_we;
  logic [23:0] i_a_addr;
  logic [15:0] i_a_din;
  logic        o_a_ack;
  logic        o_a_done;
  logic [15:0] o_a_dout;
  logic        o_a_err;
  logic        i_b_req;
  logic        i_b_we;
  logic [23:0] i_b_addr;
  logic [15:0] i_b_din;
  logic        o_b_ack;
  logic        o_b_done;
  logic [15:0] o_b_dout;
  logic        o_b_err;
  logic        o_stb;
  logic        o_we;
  logic [23:0] o_addr;
  logic [15:0] o_din;
  logic        i_busy;
  logic        i_done;
  logic [15:0] i_dout;
  logic [1:0]  o_state;
  logic        o_owner;

  modport slave (
    input  i_a_req, i_a_we, i_a_addr, i_a_din,
    input  i_b_req, i_b_we, i_b_addr, i_b_din,
    input  i_busy, i_done, i_dout,
    output o_a_ack, o_a_done, o_a_dout, o_a_err,
    output o_b_ack, o_b_done, o_b_dout, o_b_err,
    output o_stb, o_we, o_addr, o_din, o_state, o_owner
  );

  modport master (
    output i_a_req, i_a_we, i_a_addr, i_a_din,
    output i_b_req, i_b_we, i_b_addr, i_b_din,
    output i_busy, i_done, i_dout,
    input  o_a_ack, o_a_done, o_a_dout, o_a_err,
    input  o_b_ack, o_b_done, o_b_dout, o_b_err,
    input  o_stb, o_we, o_addr, o_din, o_state, o_owner
  );
endinterface

// File: rtl/psram_arbiter.sv
// rtl/psram_arbiter.sv - two-port priority arbiter for the psram controller command port
module psram_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  psram_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

  state_t        r_state, w_next;
  logic [SW-1:0] r_streak;
  logic [TW-1:0] r_tcnt;
  logic          r_rd;
  logic          r_stb, r_we, r_owner;
  logic [23:0]   r_addr;
  logic [15:0]   r_din, r_a_dout, r_b_dout;
  logic          r_a_ack, r_b_ack, r_a_done, r_b_done, r_a_err, r_b_err;
  logic          w_grant_a, w_grant_b, w_issued, w_complete, w_timeout;
  logic          w_streak_hit, w_tcnt_last;

  assign w_streak_hit = (r_streak >= SW'(STARVE_LIMIT));
  assign w_tcnt_last  = (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_grant_a  = 1'b0;
    w_grant_b  = 1'b0;
    w_issued   = 1'b0;
    w_complete = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.i_busy) begin
          if (bus.i_a_req && !(bus.i_b_req && w_streak_hit)) w_grant_a = 1'b1;
          else if (bus.i_b_req)                               w_grant_b = 1'b1;
          if (w_grant_a || w_grant_b) w_next = S_ISSUE;
        end
      end
      // Abort wins over a late busy; a done that lands on the last cycle still completes.
      S_ISSUE: begin
        if (w_tcnt_last) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end else if (bus.i_busy) begin
          w_issued = 1'b1;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.i_done) begin
          w_complete = 1'b1;
          w_next     = S_IDLE;
        end else if (w_tcnt_last) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_streak <= '0;
      r_tcnt   <= '0;
      r_rd     <= 1'b0;
      r_stb    <= 1'b0;
      r_we     <= 1'b0;
      r_owner  <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_a_dout <= '0;
      r_b_dout <= '0;
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      r_a_err  <= 1'b0;
      r_b_err  <= 1'b0;
    end else begin
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      r_a_err  <= 1'b0;
      r_b_err  <= 1'b0;
      if (r_state != S_IDLE) r_tcnt <= r_tcnt + 1'b1;
      if (r_state == S_IDLE) begin
        if (w_grant_b || !bus.i_b_req) r_streak <= '0;
        else if (w_grant_a && !w_streak_hit) r_streak <= r_streak + 1'b1;
      end
      if (w_grant_a || w_grant_b) begin
        r_we    <= w_grant_b ? bus.i_b_we   : bus.i_a_we;
        r_addr  <= w_grant_b ? bus.i_b_addr : bus.i_a_addr;
        r_din   <= w_grant_b ? bus.i_b_din  : bus.i_a_din;
        r_rd    <= w_grant_b ? !bus.i_b_we  : !bus.i_a_we;
        r_stb   <= 1'b1;
        r_owner <= w_grant_b;
        r_tcnt  <= '0;
        r_a_ack <= w_grant_a;
        r_b_ack <= w_grant_b;
      end
      if (w_issued) begin
        r_stb <= 1'b0;
        r_we  <= 1'b0;
      end
      if (w_complete) begin
        if (r_owner) begin
          r_b_done <= 1'b1;
          if (r_rd) r_b_dout <= bus.i_dout;
        end else begin
          r_a_done <= 1'b1;
          if (r_rd) r_a_dout <= bus.i_dout;
        end
      end
      if (w_timeout) begin
        r_stb   <= 1'b0;
        r_a_err <= !r_owner;
        r_b_err <= r_owner;
      end
    end
  end

  assign bus.o_state  = r_state;
  assign bus.o_owner  = r_owner;
  assign bus.o_stb    = r_stb;
  assign bus.o_we     = r_we;
  assign bus.o_addr   = r_addr;
  assign bus.o_din    = r_din;
  assign bus.o_a_ack  = r_a_ack;
  assign bus.o_b_ack  = r_b_ack;
  assign bus.o_a_done = r_a_done;
  assign bus.o_b_done = r_b_done;
  assign bus.o_a_dout = r_a_dout;
  assign bus.o_b_dout = r_b_dout;
  assign bus.o_a_err  = r_a_err;
  assign bus.o_b_err  = r_b_err;
endmodule

// File: tb/tb_psram_arbiter.sv
// tb/tb_psram_arbiter.sv - scoreboard bench with a psram controller model for psram_arbiter
module tb_psram_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  psram_arbiter_if ifc();
  psram_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(255)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (ifc)
  );

  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [23:0] a_addr = 0, b_addr = 0;
  logic [15:0] a_din = 0, b_din = 0;
  logic        force_busy = 1, c_busy = 0, c_done = 0;
  logic [15:0] c_dout = 0;

  assign ifc.i_a_req  = a_req;
  assign ifc.i_a_we   = a_we;
  assign ifc.i_a_addr = a_addr;
  assign ifc.i_a_din  = a_din;
  assign ifc.i_b_req  = b_req;
  assign ifc.i_b_we   = b_we;
  assign ifc.i_b_addr = b_addr;
  assign ifc.i_b_din  = b_din;
  assign ifc.i_busy   = force_busy | c_busy;
  assign ifc.i_done   = c_done;
  assign ifc.i_dout   = c_dout;

  typedef struct {bit is_read; bit exp_err; logic [15:0] data;} exp_t;
  typedef struct {bit we; logic [23:0] addr; logic [15:0] din;} cmd_t;
  exp_t qa[$], qb[$];
  cmd_t qc[$];
  bit   grant_log[$];
  logic [15:0] ref_mem [logic [23:0]];
  logic [15:0] ctrl_mem [logic [23:0]];

  int n_tests = 0, n_fail = 0;
  int a_left = 0, b_left = 0;
  bit hang = 0;
  int c_phase = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  // Reference: each accepted command's outcome is fixed when it is acked, since
  // transactions are strictly serial.
  task automatic push_cmd(input bit port, input bit we, input logic [23:0] addr, input logic [15:0] din);
    exp_t e;
    cmd_t c;
    e.is_read = !we;
    e.exp_err = hang;
    e.data    = we ? 16'h0000 : ref_rd(addr);
    c.we = we; c.addr = addr; c.din = din;
    qc.push_back(c);
    if (we && !hang) ref_mem[addr] = din;
    if (port) qb.push_back(e); else qa.push_back(e);
    grant_log.push_back(port);
  endtask

  task automatic new_cmd(input bit port);
    if (port) begin
      b_we = 1'($urandom_range(0, 1)); b_addr = 24'($urandom_range(0, 15)); b_din = 16'($urandom);
    end else begin
      a_we = 1'($urandom_range(0, 1)); a_addr = 24'($urandom_range(0, 15)); a_din = 16'($urandom);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (ifc.o_a_ack || ifc.o_b_ack) check("single_ack", 32'(ifc.o_a_ack & ifc.o_b_ack), 0);
    if (ifc.o_a_ack) begin
      if (a_left > 0) begin
        push_cmd(0, a_we, a_addr, a_din);
        a_left--;
        if (a_left == 0) a_req = 0; else new_cmd(0);
      end else check("spurious_a_ack", 32'(ifc.o_a_ack), 0);
    end
    if (ifc.o_b_ack) begin
      if (b_left > 0) begin
        push_cmd(1, b_we, b_addr, b_din);
        b_left--;
        if (b_left == 0) b_req = 0; else new_cmd(1);
      end else check("spurious_b_ack", 32'(ifc.o_b_ack), 0);
    end
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((a_left != 0 || b_left != 0 || qa.size() != 0 || qb.size() != 0 || c_phase != 0) && n < 3000) begin
      step();
      n++;
    end
    check({name, "_budget"}, 32'(n < 3000), 1);
  endtask

  task automatic mon(input bit port, input bit d, input bit e, input logic [15:0] dout,
                     input logic [15:0] prev, input bit owner, input logic [1:0] st);
    exp_t x;
    int   n;
    if (d || e) begin
      check("done_and_err", 32'(d & e), 0);
      n = port ? qb.size() : qa.size();
      check(port ? "b_completion_expected" : "a_completion_expected", 32'(n > 0), 1);
      if (n > 0) begin
        x = port ? qb.pop_front() : qa.pop_front();
        check(port ? "b_err_flag" : "a_err_flag", 32'(e), 32'(x.exp_err));
        if (d && x.is_read)  check(port ? "b_read_dout" : "a_read_dout", 32'(dout), 32'(x.data));
        if (d && !x.is_read) check(port ? "b_write_dout_hold" : "a_write_dout_hold", 32'(dout), 32'(prev));
        check("owner", 32'(owner), 32'(port));
        if (e) check("state_after_err", 32'(st), 0);
      end
    end
    if (!d && dout !== prev) check(port ? "b_dout_untouched" : "a_dout_untouched", 32'(dout), 32'(prev));
  endtask

  logic [15:0] pa = 0, pb = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      pa = 0;
      pb = 0;
    end else begin
      mon(0, ifc.o_a_done, ifc.o_a_err, ifc.o_a_dout, pa, ifc.o_owner, ifc.o_state);
      mon(1, ifc.o_b_done, ifc.o_b_err, ifc.o_b_dout, pb, ifc.o_owner, ifc.o_state);
      pa = ifc.o_a_dout;
      pb = ifc.o_b_dout;
    end
  end

  // Controller model: checks the command one cycle after the strobe rises, then
  // answers with busy, done and data from its own memory.
  int c_dly = 0, c_hold = 0, stb_cnt = 0;
  bit cmp_pend = 0, prev_stb = 0, cur_we = 0;
  logic [23:0] cur_addr = 0;
  always @(negedge clk) begin
    cmd_t c;
    if (!rstn) begin
      c_phase = 0; c_busy = 0; c_done = 0; cmp_pend = 0; prev_stb = 0; stb_cnt = 0;
    end else begin
      case (c_phase)
        0: if (cmp_pend) begin
          cmp_pend = 0;
          check("cmd_queue", 32'(qc.size()), 1);
          if (qc.size() > 0) begin
            c = qc.pop_front();
            check("ctl_we", 32'(ifc.o_we), 32'(c.we));
            check("ctl_addr", 32'(ifc.o_addr), 32'(c.addr));
            if (c.we) check("ctl_din", 32'(ifc.o_din), 32'(c.din));
          end
          cur_we = ifc.o_we;
          cur_addr = ifc.o_addr;
          if (!hang) begin
            if (cur_we) ctrl_mem[cur_addr] = ifc.o_din;
            c_dly = $urandom_range(0, 3);
            c_phase = 1;
          end
        end
        1: if (c_dly == 0) begin
          c_busy = 1; c_hold = $urandom_range(1, 4); c_phase = 2;
        end else c_dly--;
        2: if (c_hold == 0) begin
          c_done = 1;
          c_dout = cur_we ? 16'($urandom) : (ctrl_mem.exists(cur_addr) ? ctrl_mem[cur_addr] : 16'h0000);
          c_phase = 3;
        end else c_hold--;
        default: begin
          c_done = 0; c_busy = 0; c_phase = 0; c_dout = 16'($urandom);
        end
      endcase
      if (ifc.o_stb && !prev_stb) begin cmp_pend = 1; stb_cnt = 0; end
      if (ifc.o_stb) stb_cnt++;
      if (!ifc.o_stb && prev_stb && hang) check("timeout_stb_cycles", 32'(stb_cnt), 255);
      prev_stb = ifc.o_stb;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit bad;
    int n;
    a_req = 1; a_we = 1; a_addr = 24'hABCDEF; a_din = 16'h8765; a_left = 1;
    repeat (3) @(negedge clk);
    check("reset_pulses", {ifc.o_a_ack, ifc.o_b_ack, ifc.o_a_done, ifc.o_b_done, ifc.o_a_err, ifc.o_b_err}, 0);
    check("reset_ctl", {ifc.o_stb, ifc.o_we, ifc.o_owner, ifc.o_state, ifc.o_addr}, 0);
    rstn = 1;

    bad = 0;
    repeat (50) begin
      step();
      if (ifc.o_stb || ifc.o_a_ack) bad = 1;
    end
    check("startup_hold", 32'(bad), 0);
    force_busy = 0;
    step();
    check("startup_first_stb", 32'(ifc.o_stb), 1);
    check("startup_first_ack", 32'(a_left), 0);
    check("startup_we", 32'(ifc.o_we), 1);
    wait_quiet("a_write");

    a_req = 1; a_we = 0; a_addr = 24'hABCDEF; a_left = 1;
    wait_quiet("a_read");
    check("a_read_value", 32'(ifc.o_a_dout), 16'h8765);
    check("b_dout_idle", 32'(ifc.o_b_dout), 0);

    grant_log.delete();
    a_left = 8; b_left = 2; new_cmd(0); new_cmd(1); a_req = 1; b_req = 1;
    wait_quiet("starve");
    check("starve_grants", 32'(grant_log.size()), 10);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      check($sformatf("starve_order_%0d", i), 32'(grant_log[i]), 32'(i % 5 == 4));

    a_req = 1; a_we = 1; a_addr = 24'h000010; a_din = 16'h5A5A; a_left = 1;
    wait_quiet("a_write_10");
    b_req = 1; b_we = 0; b_addr = 24'h000010; b_left = 1;
    wait_quiet("b_alone");
    check("b_alone_dout", 32'(ifc.o_b_dout), 16'h5A5A);
    check("b_alone_owner", 32'(ifc.o_owner), 1);

    grant_log.delete();
    a_left = 4; b_left = 1; new_cmd(0); new_cmd(1); a_req = 1; b_req = 1;
    wait_quiet("starve2");
    check("starve2_grants", 32'(grant_log.size()), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check($sformatf("starve2_order_%0d", i), 32'(grant_log[i]), 32'(i == 4));

    for (int r = 0; r < 6; r++) begin
      a_left = $urandom_range(0, 6);
      b_left = $urandom_range(0, 6);
      if (a_left > 0) begin new_cmd(0); a_req = 1; end
      if (b_left > 0) begin new_cmd(1); b_req = 1; end
      wait_quiet("random");
    end

    hang = 1;
    a_req = 1; a_we = 0; a_addr = 24'h000003; a_left = 1;
    wait_quiet("timeout");
    step();
    hang = 0;
    check("timeout_state", 32'(ifc.o_state), 0);
    check("timeout_stb_low", 32'(ifc.o_stb), 0);
    a_left = 2; new_cmd(0); a_req = 1;
    wait_quiet("after_timeout");

    b_req = 1; b_we = 0; b_addr = 24'h000005; b_left = 1;
    n = 0;
    while (ifc.o_state != 2'd2 && n < 200) begin step(); n++; end
    check("reach_wait", 32'(ifc.o_state), 2);
    #2 rstn = 0;
    #1;
    check("rst_pulses", {ifc.o_a_ack, ifc.o_b_ack, ifc.o_a_done, ifc.o_b_done, ifc.o_a_err, ifc.o_b_err}, 0);
    check("rst_ctl", {ifc.o_stb, ifc.o_we, ifc.o_owner, ifc.o_state, ifc.o_addr}, 0);
    check("rst_data", {ifc.o_a_dout, ifc.o_b_dout}, 0);
    check("rst_din", 32'(ifc.o_din), 0);
    qb.delete();
    qc.delete();
    repeat (3) @(negedge clk);
    rstn = 1;
    bad = 0;
    repeat (20) begin
      step();
      if (ifc.o_b_done || ifc.o_b_err) bad = 1;
    end
    check("no_stale_done", 32'(bad), 0);
    b_req = 1; b_we = 0; b_addr = 24'h000010; b_left = 1;
    wait_quiet("after_reset");
    check("after_reset_dout", 32'(ifc.o_b_dout), 16'h5A5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
